alu: RTL and testbench



---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_logic_core.sv | 27 ++
 rtl/alu.sv | 44 ++++
 tb/tb_alu.sv | 126 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the bitwise ALU.
// Opcode encoding and default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_NOT = 2'b01,
    OP_XOR = 2'b10,
    OP_OR  = 2'b11
  } alu_op_t;

endpackage

// File: rtl/alu_logic_core.sv
// Combinational bitwise core of the ALU.
// Produces the result and its all-zeros flag.
module alu_logic_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] res,
  output logic             res_zero
);

  always_comb begin
    res = a | b;
    unique case (op)
      OP_AND:  res = a & b;
      OP_NOT:  res = ~a;
      OP_XOR:  res = a ^ b;
      default: res = a | b;
    endcase
  end

  assign res_zero = ~|res;

endmodule

// File: rtl/alu.sv
// Bitwise ALU with a single output register stage.
// Y/zero hold on idle cycles; out_valid marks fresh results.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       opcode,
  output logic [WIDTH-1:0] Y,
  output logic             zero,
  output logic             out_valid
);

  logic [WIDTH-1:0] res;
  logic             res_zero;

  alu_logic_core #(.WIDTH(WIDTH)) u_core (
    .a       (A),
    .b       (B),
    .op      (alu_op_t'(opcode)),
    .res     (res),
    .res_zero(res_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y         <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Y    <= res;
        zero <= res_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the bitwise ALU.
// Expected values are hand-computed constants.
module tb_alu;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] A;
  logic [7:0] B;
  logic [1:0] opcode;
  logic [7:0] Y;
  logic       zero;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

  alu #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .opcode   (opcode),
    .Y        (Y),
    .zero     (zero),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] ey,
                     input logic ez, input logic ev);
    checks++;
    assert (Y === ey && zero === ez && out_valid === ev)
    else begin
      errors++;
      $error("FAIL %s: Y=%h zero=%b ov=%b, want Y=%h zero=%b ov=%b",
             tag, Y, zero, out_valid, ey, ez, ev);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op,
                       input logic [7:0] a, input logic [7:0] b);
    in_valid = v;
    opcode   = op;
    A        = a;
    B        = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    opcode = 2'b00;
    A = 8'h00;
    B = 8'h00;
    // load a nonzero result so the asynchronous clear is observable
    drive(1'b1, 2'b11, 8'hF0, 8'h0F);
    chk("preload", 8'hFF, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", 8'h00, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("reset_hold", 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, 2'b00, 8'hFF, 8'hFF);
    chk("idle_after_reset", 8'h00, 1'b1, 1'b0);

    drive(1'b1, 2'b00, 8'b11001100, 8'b10101010);
    chk("and", 8'b10001000, 1'b0, 1'b1);
    drive(1'b1, 2'b01, 8'b11001100, 8'hFF);
    chk("not_b_ignored", 8'b00110011, 1'b0, 1'b1);
    drive(1'b1, 2'b01, 8'hFF, 8'h00);
    chk("not_ff", 8'h00, 1'b1, 1'b1);

    drive(1'b1, 2'b10, 8'b11001100, 8'b10101010);
    chk("xor", 8'b01100110, 1'b0, 1'b1);
    drive(1'b1, 2'b11, 8'b11001100, 8'b10101010);
    chk("or_b2b", 8'b11101110, 1'b0, 1'b1);
    drive(1'b1, 2'b00, 8'h0F, 8'hF0);
    chk("and_disjoint", 8'h00, 1'b1, 1'b1);
    drive(1'b1, 2'b10, 8'h3C, 8'h00);
    chk("xor_zero_b", 8'h3C, 1'b0, 1'b1);

    drive(1'b1, 2'b10, 8'h5A, 8'h5A);
    chk("xor_equal", 8'h00, 1'b1, 1'b1);
    drive(1'b0, 2'b11, 8'h12, 8'h34);
    chk("hold1", 8'h00, 1'b1, 1'b0);
    drive(1'b0, 2'b01, 8'h00, 8'hAB);
    chk("hold2", 8'h00, 1'b1, 1'b0);

    drive(1'b1, 2'b11, 8'h81, 8'h18);
    chk("or_pre_mid", 8'h99, 1'b0, 1'b1);
    // valid OR presented, reset lands before its capture edge
    @(negedge clk);
    in_valid = 1'b1;
    opcode = 2'b11;
    A = 8'hA0;
    B = 8'h05;
    #1;
    rst = 1'b1;
    #1;
    chk("mid_reset", 8'h00, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("mid_reset_edge", 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("discarded", 8'h00, 1'b1, 1'b0);
    drive(1'b1, 2'b11, 8'hA0, 8'h05);
    chk("after_mid_reset", 8'hA5, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
